// File: rtl/tt_sweep_ctrl_if.sv
// Signal bundle between the truth-table sweep controller and its two
// table units / host: request inputs, unit outputs, stimulus and results.
interface tt_sweep_ctrl_if;
   logic       start;
   logic       abort;
   logic       y1;
   logic       y2;
   logic       a;
   logic       b;
   logic       c;
   logic       sel;
   logic [7:0] tt1;
   logic [7:0] tt2;
   logic       busy;
   logic       done;
   logic       pass1;
   logic       pass2;

   // Host / table-unit side
   modport master (
      output start, abort, y1, y2,
      input  a, b, c, sel, tt1, tt2, busy, done, pass1, pass2
   );

   // Controller side
   modport slave (
      input  start, abort, y1, y2,
      output a, b, c, sel, tt1, tt2, busy, done, pass1, pass2
   );
endinterface

// File: rtl/tt_sweep_ctrl.sv
// Clocked sequencer that sweeps all 8 {a,b,c} combinations through table 1
// and then table 2, captures each unit's output after a settle delay, and
// checks both captured tables against expected constants.
module tt_sweep_ctrl #(
   parameter int unsigned SETTLE = 2,      // 1..15
   parameter logic [7:0]  EXP1   = 8'hEA,
   parameter logic [7:0]  EXP2   = 8'h96
) (
   input logic           clk,
   input logic           reset,
   tt_sweep_ctrl_if.slave bus
);

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_DRIVE  = 2'd1,
      ST_SAMPLE = 2'd2,
      ST_DONE   = 2'd3
   } state_t;

   localparam logic [3:0] CNT_LAST = 4'(SETTLE - 1);

   state_t     state_q, state_d;
   logic [2:0] vec_q, vec_d;
   logic       sel_q, sel_d;
   logic [3:0] cnt_q, cnt_d;
   logic [7:0] tt1_q, tt1_d;
   logic [7:0] tt2_q, tt2_d;
   logic       busy_q, busy_d;
   logic       done_q, done_d;
   logic       pass1_q, pass1_d;
   logic       pass2_q, pass2_d;

   // State and output registers with synchronous reset
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= ST_IDLE;
         vec_q   <= '0;
         sel_q   <= 1'b0;
         cnt_q   <= '0;
         tt1_q   <= '0;
         tt2_q   <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         pass1_q <= 1'b0;
         pass2_q <= 1'b0;
      end else begin
         state_q <= state_d;
         vec_q   <= vec_d;
         sel_q   <= sel_d;
         cnt_q   <= cnt_d;
         tt1_q   <= tt1_d;
         tt2_q   <= tt2_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         pass1_q <= pass1_d;
         pass2_q <= pass2_d;
      end
   end

   // Next-state and next-output logic for the sweep sequence
   always_comb begin
      state_d = state_q;
      vec_d   = vec_q;
      sel_d   = sel_q;
      cnt_d   = cnt_q;
      tt1_d   = tt1_q;
      tt2_d   = tt2_q;
      busy_d  = busy_q;
      done_d  = 1'b0;
      pass1_d = pass1_q;
      pass2_d = pass2_q;

      unique case (state_q)
         ST_IDLE: begin
            if (bus.start) begin
               tt1_d   = '0;
               tt2_d   = '0;
               pass1_d = 1'b0;
               pass2_d = 1'b0;
               vec_d   = '0;
               sel_d   = 1'b0;
               cnt_d   = '0;
               busy_d  = 1'b1;
               state_d = ST_DRIVE;
            end
         end

         ST_DRIVE: begin
            if (bus.abort) begin
               busy_d  = 1'b0;
               pass1_d = 1'b0;
               pass2_d = 1'b0;
               state_d = ST_IDLE;
            end else begin
               cnt_d = cnt_q + 4'd1;
               if (cnt_q == CNT_LAST) begin
                  state_d = ST_SAMPLE;
               end
            end
         end

         ST_SAMPLE: begin
            if (bus.abort) begin
               busy_d  = 1'b0;
               pass1_d = 1'b0;
               pass2_d = 1'b0;
               state_d = ST_IDLE;
            end else begin
               if (!sel_q) begin
                  tt1_d[vec_q] = bus.y1;
               end else begin
                  tt2_d[vec_q] = bus.y2;
               end
               if (vec_q != 3'd7) begin
                  vec_d   = vec_q + 3'd1;
                  cnt_d   = '0;
                  state_d = ST_DRIVE;
               end else if (!sel_q) begin
                  vec_d   = '0;
                  sel_d   = 1'b1;
                  cnt_d   = '0;
                  state_d = ST_DRIVE;
               end else begin
                  // Compare against the tables including the final sample so
                  // pass flags are already valid in the done cycle.
                  busy_d  = 1'b0;
                  done_d  = 1'b1;
                  pass1_d = (tt1_d == EXP1);
                  pass2_d = (tt2_d == EXP2);
                  state_d = ST_DONE;
               end
            end
         end

         ST_DONE: begin
            pass1_d = (tt1_q == EXP1);
            pass2_d = (tt2_q == EXP2);
            state_d = ST_IDLE;
         end

         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   assign bus.a     = vec_q[2];
   assign bus.b     = vec_q[1];
   assign bus.c     = vec_q[0];
   assign bus.sel   = sel_q;
   assign bus.tt1   = tt1_q;
   assign bus.tt2   = tt2_q;
   assign bus.busy  = busy_q;
   assign bus.done  = done_q;
   assign bus.pass1 = pass1_q;
   assign bus.pass2 = pass2_q;

endmodule

// File: doc/tt_sweep_ctrl.md
Name: tt_sweep_ctrl

Overview:
- Sequencer that time-shares one 3-input stimulus bus {a,b,c} between two combinational truth-table units (table 1, table 2).
- On start, sweeps all 8 input combinations through table 1, then table 2.
- Samples each unit's output after a settle delay and assembles an 8-bit captured truth table per unit.
- Compares each captured table against its expected constant and reports pass/fail with a done pulse.
- Replaces open-loop timed stimulus with a clocked, self-checking controller.

Parameters:
- SETTLE, 2, cycles the stimulus is held before sampling; legal range 1..15.
- EXP1, 8'hEA, expected table 1 contents; bit i = output for {a,b,c} = i.
- EXP2, 8'h96, expected table 2 contents; same bit ordering.

Ports:
- clk  input  1  system clock, rising edge
- reset  input  1  synchronous, active-high reset
- start  input  1  one-cycle request to begin a sweep; honoured only in IDLE
- abort  input  1  cancel an in-progress sweep
- y1  input  1  output of table 1 unit
- y2  input  1  output of table 2 unit
- a  output  1  stimulus MSB (vec[2])
- b  output  1  stimulus (vec[1])
- c  output  1  stimulus LSB (vec[0])
- sel  output  1  table currently being swept (0 = table 1, 1 = table 2)
- tt1  output  8  captured table 1
- tt2  output  8  captured table 2
- busy  output  1  sweep in progress
- done  output  1  one-cycle completion pulse
- pass1  output  1  tt1 == EXP1, valid from done onward
- pass2  output  1  tt2 == EXP2, valid from done onward

Behaviour:
- Interface: one clock (clk); reset is synchronous and active-high. On reset every output and internal register is 0 (vec=0, sel=0, tt1=tt2=0, busy=done=pass1=pass2=0) and the state is IDLE.
- All outputs are registered.
- States: IDLE, DRIVE, SAMPLE, DONE.
- IDLE:
  - When start=1: clear tt1, tt2, pass1 and pass2; set vec=0, sel=0, cnt=0; go to DRIVE.
  - busy=1 from the next cycle.
- DRIVE:
  - Hold {a,b,c}=vec and increment cnt each cycle.
  - When cnt reaches SETTLE-1, go to SAMPLE. DRIVE therefore lasts exactly SETTLE cycles.
- SAMPLE (1 cycle):
  - sel=0: tt1[vec] <= y1. sel=1: tt2[vec] <= y2.
  - If vec<7: vec+1, cnt=0, go to DRIVE.
  - If vec==7 and sel==0: vec wraps to 0, sel=1, cnt=0, go to DRIVE.
  - If vec==7 and sel==1: go to DONE.
- DONE (1 cycle):
  - done=1 and busy=0.
  - pass1 <= (tt1==EXP1) and pass2 <= (tt2==EXP2).
  - Next state is IDLE.
  - tt1, tt2, pass1 and pass2 hold until the next accepted start.
- Latency: with start sampled at edge 0, busy is high for exactly 16*(SETTLE+1) cycles and done is high in the following cycle.
- vec is 3 bits, and the wrap 7->0 occurs only at the table-1 to table-2 boundary.
- start while busy or in DONE: ignored, with no effect on the sweep.
- abort (DRIVE or SAMPLE): next state IDLE, busy=0, done stays 0, pass1=pass2=0, and partial tt1/tt2 are retained.
- Simultaneous events:
  - abort has priority over a SAMPLE transition.
  - start and abort together in IDLE: start wins; abort has no meaning in IDLE.
- reset mid-sweep: immediately returns everything to its reset values; no done pulse.

Test Plan:
- Reset: assert reset for 2 cycles during a sweep -> all outputs 0 and state IDLE; no done pulse.
- Full sweep, SETTLE=2: bench models y1=(a&b)|c and y2=a^b^c; pulse start -> {a,b,c} steps 000..111 with sel=0, then again with sel=1, each value held 3 cycles; busy high 48 cycles; done pulses once; tt1=8'hEA, tt2=8'h96, pass1=pass2=1.
- Mismatch: y2 stub forced to 0, same sweep -> tt1=8'hEA, tt2=8'h00, pass1=1, pass2=0.
- Ignored start: pulse start again at cycle 10 of a sweep -> sequence and 48-cycle busy length unchanged; exactly one done.
- Abort: assert abort while sel=0 and vec=5 -> next cycle busy=0 and done never pulses; tt1 holds bits 0..4 captured; pass1=pass2=0; a following start runs a clean full sweep.
- Boundary, SETTLE=1: sweep -> each vector held 2 cycles; busy=32 cycles; sel rises exactly at the cycle after the vec=7 sample, with vec=0.
